// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, one bit per clock, LSB first.
// Each bit is a full-add slice made of two half-add steps plus a
// registered carry. Operands are captured on an accepted start. The sum and
// carry-out are registered and held until the next completion or reset.
// Optional: define SERIAL_ADDER_OVF_EN to add the OVF signed-overflow output.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             COUT
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  logic             w_accept;
  logic             w_last;
  logic             w_h1;
  logic             w_c1;
  logic             w_sbit;
  logic             w_c2;
  logic             w_carry_nxt;

  // Half-adder sum
  function automatic logic ha_sum(input logic x, input logic y);
    return x ^ y;
  endfunction

  // Half-adder carry
  function automatic logic ha_carry(input logic x, input logic y);
    return x & y;
  endfunction

  // Full-add slice: first half-add on the operand bits, second half-add
  // folds in the registered carry.
  assign w_h1        = ha_sum(r_a_sr[0], r_b_sr[0]);
  assign w_c1        = ha_carry(r_a_sr[0], r_b_sr[0]);
  assign w_sbit      = ha_sum(w_h1, r_carry);
  assign w_c2        = ha_carry(w_h1, r_carry);
  assign w_carry_nxt = w_c1 | w_c2;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and status outputs; start is only honoured outside RUN
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) w_next = RUN;
        else       w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Serial datapath: load on accept, one bit per RUN edge, publish on last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_s      <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sr   <= A;
      r_b_sr   <= B;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_sum_sr <= {w_sbit, r_sum_sr[WIDTH-1:1]};
      r_carry  <= w_carry_nxt;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_s    <= {w_sbit, r_sum_sr[WIDTH-1:1]};
        r_cout <= w_carry_nxt;
      end
    end
  end

  assign S    = r_s;
  assign COUT = r_cout;

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into the MSB slice differs from carry out of it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if ((r_state == RUN) && !w_accept && w_last) begin
      r_ovf <= r_carry ^ w_carry_nxt;
    end
  end

  assign OVF = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl (WIDTH=8): directed vectors, scoreboard
// queue filled by the stimulus, drained by a monitor on every done pulse.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] s_out;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;
  logic done_prev = 1'b0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (a_in),
    .B    (b_in),
    .busy (busy),
    .done (done),
    .S    (s_out),
    .COUT (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .OVF  (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse pops one expected result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      chk("done_width", 32'(done_prev), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("S", 32'(s_out), 32'(e.s));
        chk("COUT", 32'(cout), 32'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
        chk("OVF", 32'(ovf), 32'(e.o));
`endif
      end
    end
    done_prev = done;
  end

  // Called just after a negedge: present start for the next posedge, leave
  // on the following negedge (first RUN cycle) with start released.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic push, input logic [W-1:0] es,
                       input logic ec, input logic eo);
    exp_t e;
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    if (push) begin
      e.s = es; e.c = ec; e.o = eo;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
  endtask

  // Wait for done starting from the first RUN cycle (k=1); returns at the
  // negedge where done is seen.
  task automatic wait_done(input int k0, input logic timing);
    int k;
    int nb;
    k  = k0;
    nb = (k0 > 1) ? (k0 - 1) : 0;
    while (done !== 1'b1 && k < 40) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      k++;
    end
    chk("done_seen", 32'(done), 32'd1);
    if (timing) begin
      chk("latency", 32'(k), 32'(W + 1));
      chk("busy_cycles", 32'(nb), 32'(W));
    end
  endtask

  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] es, input logic ec, input logic eo);
    issue(a, b, 1'b1, es, ec, eo);
    wait_done(1, 1'b1);
    @(negedge clk);
    chk("done_cleared", 32'(done), 32'd0);
  endtask

  initial begin
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_S", 32'(s_out), 32'd0);
    chk("rst_COUT", 32'(cout), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_add(8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
    run_add(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_add(8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
    run_add(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);

    // start during RUN is ignored
    d0 = n_done;
    issue(8'h10, 8'h20, 1'b1, 8'h30, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a_in = 8'hAA; b_in = 8'h55;
    @(negedge clk);
    start = 1'b0;
    wait_done(4, 1'b1);
    repeat (W + 4) @(negedge clk);
    chk("single_done", 32'(n_done - d0), 32'd1);

    // reset mid-RUN aborts
    d0 = n_done;
    issue(8'h0F, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_S", 32'(s_out), 32'd0);
    chk("abort_COUT", 32'(cout), 32'd0);
    repeat (W + 4) @(negedge clk);
    chk("abort_no_done", 32'(n_done - d0), 32'd0);
    run_add(8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);

    // back-to-back: start held through DONE
    issue(8'h12, 8'h34, 1'b1, 8'h46, 1'b0, 1'b0);
    wait_done(1, 1'b1);
    issue(8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b1);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(1, 1'b1);
    @(negedge clk);
    chk("S_held", 32'(s_out), 32'h00);
    chk("COUT_held", 32'(cout), 32'd1);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
